// File: rtl/move_command_gen_if.sv
// Request/command bundle between a move requester, move_command_gen and the driven counter.
// The slave modport belongs to the generator; the master modport drives requests and count feedback.
interface move_command_gen_if #(
  parameter int W = 4
) ();
  logic         req_inc;
  logic         req_dec;
  logic         req_res;
  logic [W-1:0] count_in;
  logic [1:0]   control;
  logic         busy;
  logic         at_min;
  logic         at_max;

  modport slave (
    input  req_inc, req_dec, req_res, count_in,
    output control, busy, at_min, at_max
  );

  modport master (
    output req_inc, req_dec, req_res, count_in,
    input  control, busy, at_min, at_max
  );
endinterface

// File: rtl/move_command_gen.sv
// Turns level inc/dec/reset requests into one-cycle counter commands, then enforces a cooldown.
// Inc and dec are suppressed at the bounds so the driven counter never wraps.
module move_command_gen #(
  parameter int W        = 4,
  parameter int MIN_VAL  = 0,
  parameter int MAX_VAL  = (1 << W) - 1,
  parameter int COOLDOWN = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  move_command_gen_if.slave bus
);
  localparam int               CNT_W    = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN - 1);
  localparam logic [W-1:0]     MIN_L    = W'(MIN_VAL);
  localparam logic [W-1:0]     MAX_L    = W'(MAX_VAL);

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_INC  = 2'b01;
  localparam logic [1:0] CMD_DEC  = 2'b10;
  localparam logic [1:0] CMD_RES  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_COOLDOWN
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       control_q;
  logic             busy_q;
  logic [1:0]       cmd_d;
  logic             at_min;
  logic             at_max;

  assign at_min = (bus.count_in <= MIN_L);
  assign at_max = (bus.count_in >= MAX_L);

  // Reset wins outright; conflicting inc+dec selects nothing.
  always_comb begin
    cmd_d = CMD_HOLD;
    if (bus.req_res) begin
      cmd_d = CMD_RES;
    end else if (bus.req_inc && !bus.req_dec && !at_max) begin
      cmd_d = CMD_INC;
    end else if (bus.req_dec && !bus.req_inc && !at_min) begin
      cmd_d = CMD_DEC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      control_q <= CMD_HOLD;
      busy_q    <= 1'b0;
    end else begin
      control_q <= CMD_HOLD;
      case (state_q)
        S_IDLE: begin
          if (cmd_d != CMD_HOLD) begin
            state_q   <= S_ISSUE;
            control_q <= cmd_d;
            busy_q    <= 1'b1;
          end
        end
        S_ISSUE: begin
          state_q <= S_COOLDOWN;
          cnt_q   <= CNT_LOAD;
          busy_q  <= 1'b1;
        end
        S_COOLDOWN: begin
          if (bus.req_res) begin
            state_q   <= S_ISSUE;
            control_q <= CMD_RES;
            busy_q    <= 1'b1;
          end else if (cnt_q == '0) begin
            // The expiry edge doubles as the IDLE sampling point, so a held
            // request repeats every COOLDOWN+1 cycles.
            if (cmd_d != CMD_HOLD) begin
              state_q   <= S_ISSUE;
              control_q <= cmd_d;
              busy_q    <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.control = control_q;
  assign bus.busy    = busy_q;
  assign bus.at_min  = at_min;
  assign bus.at_max  = at_max;
endmodule

// File: tb/tb_move_command_gen.sv
// Directed bench for move_command_gen (W=4, COOLDOWN=8): expected control/busy per cycle
// are queued as stimulus is driven and compared one cycle later against the DUT.
module tb_move_command_gen;
  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  typedef struct {
    logic [1:0] c;
    logic       b;
    string      tag;
  } exp_t;

  exp_t sb[$];

  move_command_gen_if #(.W(4)) bus ();

  move_command_gen #(
    .W(4), .MIN_VAL(0), .MAX_VAL(15), .COOLDOWN(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Queue the expectation for the cycle after the coming edge, then compare it.
  task automatic cyc(input logic [1:0] ec, input logic eb, input string tag);
    exp_t e;
    e.c = ec; e.b = eb; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, "_ctrl"}, {2'b00, bus.control}, {2'b00, e.c});
    check({e.tag, "_busy"}, {3'b000, bus.busy}, {3'b000, e.b});
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst_n       = 1'b0;
    bus.req_inc = 1'b0;
    bus.req_dec = 1'b0;
    bus.req_res = 1'b1;
    bus.count_in = 4'd3;

    // Reset, with a reset request pending that must be overridden.
    cyc(2'b00, 1'b0, "reset0");
    bus.req_res = 1'b0;
    cyc(2'b00, 1'b0, "reset1");
    check("flags_mid_min", {3'b000, bus.at_min}, 4'h0);
    check("flags_mid_max", {3'b000, bus.at_max}, 4'h0);
    rst_n = 1'b1;

    // Single inc pulse.
    bus.req_inc = 1'b1;
    cyc(2'b01, 1'b1, "pulse_issue");
    bus.req_inc = 1'b0;
    for (int i = 0; i < 8; i++) cyc(2'b00, 1'b1, "pulse_cool");
    cyc(2'b00, 1'b0, "pulse_idle");

    // Held inc for 30 cycles: commands on cycles 1, 10, 19, 28.
    bus.req_inc = 1'b1;
    for (int i = 1; i <= 30; i++) cyc((i % 9 == 1) ? 2'b01 : 2'b00, 1'b1, "held");
    bus.req_inc = 1'b0;
    for (int i = 31; i <= 36; i++) cyc(2'b00, 1'b1, "held_drain");
    cyc(2'b00, 1'b0, "held_idle");

    // Bounds: no inc at max, no dec at min.
    bus.count_in = 4'd15;
    bus.req_inc  = 1'b1;
    #1;
    check("at_max_hi", {3'b000, bus.at_max}, 4'h1);
    check("at_min_lo", {3'b000, bus.at_min}, 4'h0);
    for (int i = 0; i < 4; i++) cyc(2'b00, 1'b0, "inc_at_max");
    bus.req_inc  = 1'b0;
    bus.count_in = 4'd0;
    bus.req_dec  = 1'b1;
    #1;
    check("at_min_hi", {3'b000, bus.at_min}, 4'h1);
    check("at_max_lo", {3'b000, bus.at_max}, 4'h0);
    for (int i = 0; i < 4; i++) cyc(2'b00, 1'b0, "dec_at_min");
    bus.count_in = 4'd3;

    // Conflicting inc+dec, then reset request on top.
    bus.req_inc = 1'b1;
    for (int i = 0; i < 3; i++) cyc(2'b00, 1'b0, "inc_dec_both");
    bus.req_res = 1'b1;
    cyc(2'b11, 1'b1, "res_prio");
    bus.req_res = 1'b0;
    bus.req_inc = 1'b0;
    bus.req_dec = 1'b0;
    for (int i = 0; i < 8; i++) cyc(2'b00, 1'b1, "res_cool");
    cyc(2'b00, 1'b0, "res_idle");

    // Reset request during the 3rd cooldown cycle aborts it.
    bus.req_dec = 1'b1;
    cyc(2'b10, 1'b1, "dec_issue");
    bus.req_dec = 1'b0;
    for (int i = 0; i < 3; i++) cyc(2'b00, 1'b1, "abort_cool");
    bus.req_res = 1'b1;
    cyc(2'b11, 1'b1, "abort_res");
    bus.req_res = 1'b0;
    for (int i = 0; i < 8; i++) cyc(2'b00, 1'b1, "abort_fresh");
    cyc(2'b00, 1'b0, "abort_idle");

    // Reset request sampled in ISSUE is ignored.
    bus.req_inc = 1'b1;
    cyc(2'b01, 1'b1, "issue_res_inc");
    bus.req_inc = 1'b0;
    bus.req_res = 1'b1;
    cyc(2'b00, 1'b1, "issue_res_ign");
    bus.req_res = 1'b0;
    for (int i = 0; i < 7; i++) cyc(2'b00, 1'b1, "issue_res_cool");
    cyc(2'b00, 1'b0, "issue_res_idle");

    // rst_n mid-ISSUE and mid-COOLDOWN, each followed by an immediate new request.
    bus.req_inc = 1'b1;
    cyc(2'b01, 1'b1, "rst_issue_a");
    rst_n = 1'b0;
    bus.req_inc = 1'b0;
    cyc(2'b00, 1'b0, "rst_in_issue");
    rst_n = 1'b1;
    bus.req_inc = 1'b1;
    cyc(2'b01, 1'b1, "rst_after_issue");
    bus.req_inc = 1'b0;
    for (int i = 0; i < 3; i++) cyc(2'b00, 1'b1, "rst_cool_pre");
    rst_n = 1'b0;
    cyc(2'b00, 1'b0, "rst_in_cool");
    rst_n = 1'b1;
    bus.req_dec = 1'b1;
    cyc(2'b10, 1'b1, "rst_after_cool");
    bus.req_dec = 1'b0;
    for (int i = 0; i < 8; i++) cyc(2'b00, 1'b1, "rst_final_cool");
    cyc(2'b00, 1'b0, "rst_final_idle");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/move_command_gen.md
MOVE_COMMAND_GEN -- requirements
Module: move_command_gen

Interface
REQ-001 SHALL have parameter W, default 4: width of the driven counter and of count_in.
REQ-002 SHALL have parameter MIN_VAL, default 0: lower step bound; no dec is issued at or below it.
REQ-003 SHALL have parameter MAX_VAL, default 2^W-1: upper step bound; no inc is issued at or above it.
REQ-004 SHALL have parameter COOLDOWN, default 8, legal range 1..255: idle cycles forced after each issued command.
REQ-005 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  input  1: synchronous, active-low reset.
REQ-007 SHALL have port req_inc  input  1: level request to step the counter up.
REQ-008 SHALL have port req_dec  input  1: level request to step the counter down.
REQ-009 SHALL have port req_res  input  1: level request to clear the counter.
REQ-010 SHALL have port count_in  input  W: current value fed back from the driven counter.
REQ-011 SHALL have port control  output  2: registered command to the counter; 00 hold, 01 inc, 10 dec, 11 res.
REQ-012 SHALL have port busy  output  1: registered; high in ISSUE and COOLDOWN states.
REQ-013 SHALL have port at_min  output  1: combinational; high when count_in <= MIN_VAL.
REQ-014 SHALL have port at_max  output  1: combinational; high when count_in >= MAX_VAL.

Function
REQ-015 SHALL implement the three-state FSM IDLE, ISSUE, COOLDOWN.
REQ-016 SHALL, in IDLE, select the command by priority: req_res, then inc/dec; req_inc and req_dec both high selects no command.
REQ-017 SHALL suppress an inc request while at_max is high and a dec request while at_min is high, remaining in IDLE, so the counter never wraps.
REQ-018 SHALL, on a selected command sampled at edge k, move to ISSUE and drive control with that code during the cycle after edge k only, for one-cycle latency.
REQ-019 SHALL drive control = 00 in every state except ISSUE.
REQ-020 SHALL move from ISSUE to COOLDOWN unconditionally after one cycle, loading the cooldown counter with COOLDOWN-1.
REQ-021 SHALL remain in COOLDOWN for exactly COOLDOWN cycles, then return to IDLE; a held request therefore repeats every COOLDOWN+1 cycles.
REQ-022 SHALL ignore req_inc and req_dec while busy is high, without queuing them.
REQ-023 SHALL abort COOLDOWN when req_res is sampled high in COOLDOWN, entering ISSUE with control = 11 on the next cycle.
REQ-024 SHALL ignore req_res sampled in ISSUE, where control already holds a code.
REQ-025 SHALL size the cooldown counter to hold COOLDOWN-1; a COOLDOWN value of 1 gives exactly one idle cycle.
REQ-026 SHALL keep at_min and at_max purely as functions of count_in, independent of FSM state.

Reset
REQ-027 SHALL, when rst_n is sampled low at a rising edge, enter IDLE, set control = 00 and busy = 0, and clear the cooldown counter.
REQ-028 SHALL give reset priority over every request and state, including mid-ISSUE and mid-COOLDOWN.
REQ-029 SHALL treat requests sampled on the first edge with rst_n high as normal IDLE requests.

Verification
REQ-030 Bench SHALL apply reset, then pulse req_inc for one cycle with count_in = 3 -> control = 01 for exactly one cycle, one cycle after sampling, then busy high for 8 more cycles.
REQ-031 Bench SHALL hold req_inc high for 30 cycles with COOLDOWN = 8 -> control = 01 on cycles 1, 10, 19 and 28 only.
REQ-032 Bench SHALL hold req_inc with count_in = 15 (W = 4) -> control stays 00, busy stays 0 and at_max = 1.
REQ-033 Bench SHALL assert req_inc and req_dec together -> control stays 00; adding req_res -> control = 11 for one cycle.
REQ-034 Bench SHALL assert req_res on the 3rd COOLDOWN cycle -> control = 11 on the next cycle, followed by a fresh 8-cycle COOLDOWN.
REQ-035 Bench SHALL pull rst_n low during ISSUE and during COOLDOWN -> control = 00, busy = 0 at the next edge, and a new request is accepted immediately after release.
